// File: rtl/acc_alu_ctrl_core.sv
// Execution core of the 8-bit accumulator machine: fetch/execute controller,
// accumulator, combinational ALU and Z/N/C flag register.
//
// state   | meaning
// FETCH   | IR loads, PC increments
// EXECUTE | decode IR, update acc/flags, drive PC/reg-file strobes
// HALT    | parked until reset, only halt asserted
module acc_alu_ctrl_core #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       instr,
   input  logic [WIDTH-1:0] reg_data,
   output logic [WIDTH-1:0] acc_out,
   output logic             load_ir,
   output logic             inc_pc,
   output logic             load_pc,
   output logic             sel_pc,
   output logic             load_reg,
   output logic             halt,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c
);

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      EXECUTE = 2'd1,
      HALTED  = 2'd2
   } state_t;

   localparam logic [3:0] OP_LDI = 4'h1;
   localparam logic [3:0] OP_LDR = 4'h2;
   localparam logic [3:0] OP_STR = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_SUB = 4'h5;
   localparam logic [3:0] OP_AND = 4'h6;
   localparam logic [3:0] OP_OR  = 4'h7;
   localparam logic [3:0] OP_XOR = 4'h8;
   localparam logic [3:0] OP_NOT = 4'h9;
   localparam logic [3:0] OP_SHL = 4'hA;
   localparam logic [3:0] OP_SHR = 4'hB;
   localparam logic [3:0] OP_JMP = 4'hC;
   localparam logic [3:0] OP_JZ  = 4'hD;
   localparam logic [3:0] OP_JN  = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   state_t           state, state_next;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_op;
   logic [WIDTH-1:0] imm_ext;
   logic [3:0]       opcode;

   assign opcode  = instr[7:4];
   assign imm_ext = {{(WIDTH-4){1'b0}}, instr[3:0]};
   assign acc_out = acc;

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_op  = 1'b1;
      case (opcode)
         OP_ADD: {alu_c, alu_res} = {1'b0, acc} + {1'b0, reg_data};
         OP_SUB: begin
            alu_res = acc - reg_data;
            alu_c   = (acc < reg_data);
         end
         OP_AND: alu_res = acc & reg_data;
         OP_OR:  alu_res = acc | reg_data;
         OP_XOR: alu_res = acc ^ reg_data;
         OP_NOT: alu_res = ~acc;
         OP_SHL: begin
            alu_res = {acc[WIDTH-2:0], 1'b0};
            alu_c   = acc[WIDTH-1];
         end
         OP_SHR: begin
            alu_res = {1'b0, acc[WIDTH-1:1]};
            alu_c   = acc[0];
         end
         default: alu_op = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= state_next;
      end
   end

   // Strobes are forced low while reset is held, whatever the state register says.
   always_comb begin
      state_next = state;
      load_ir    = 1'b0;
      inc_pc     = 1'b0;
      load_pc    = 1'b0;
      sel_pc     = 1'b0;
      load_reg   = 1'b0;
      halt       = 1'b0;
      case (state)
         FETCH: begin
            load_ir    = 1'b1;
            inc_pc     = 1'b1;
            state_next = EXECUTE;
         end
         EXECUTE: begin
            state_next = FETCH;
            case (opcode)
               OP_STR: load_reg = 1'b1;
               OP_JMP: begin
                  load_pc = 1'b1;
                  sel_pc  = 1'b1;
               end
               OP_JZ: begin
                  load_pc = flag_z;
                  sel_pc  = flag_z;
               end
               OP_JN: begin
                  load_pc = flag_n;
                  sel_pc  = flag_n;
               end
               OP_HLT: state_next = HALTED;
               default: ;
            endcase
         end
         HALTED: halt = 1'b1;
         default: state_next = FETCH;
      endcase
      if (reset) begin
         load_ir  = 1'b0;
         inc_pc   = 1'b0;
         load_pc  = 1'b0;
         sel_pc   = 1'b0;
         load_reg = 1'b0;
         halt     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc    <= '0;
         flag_z <= 1'b0;
         flag_n <= 1'b0;
         flag_c <= 1'b0;
      end else if (state == EXECUTE) begin
         if (opcode == OP_LDI) begin
            acc <= imm_ext;
         end else if (opcode == OP_LDR) begin
            acc <= reg_data;
         end else if (alu_op) begin
            acc    <= alu_res;
            flag_z <= (alu_res == '0);
            flag_n <= alu_res[WIDTH-1];
            flag_c <= alu_c;
         end
      end
   end

endmodule

// File: tb/tb_acc_alu_ctrl_core.sv
// Randomised scoreboard bench for acc_alu_ctrl_core against an arithmetic
// reference model of the instruction set.
module tb_acc_alu_ctrl_core;

   logic       clk;
   logic       reset;
   logic [7:0] instr;
   logic [7:0] reg_data;
   logic [7:0] acc_out;
   logic       load_ir, inc_pc, load_pc, sel_pc, load_reg, halt;
   logic       flag_z, flag_n, flag_c;

   acc_alu_ctrl_core #(.WIDTH(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .instr    (instr),
      .reg_data (reg_data),
      .acc_out  (acc_out),
      .load_ir  (load_ir),
      .inc_pc   (inc_pc),
      .load_pc  (load_pc),
      .sel_pc   (sel_pc),
      .load_reg (load_reg),
      .halt     (halt),
      .flag_z   (flag_z),
      .flag_n   (flag_n),
      .flag_c   (flag_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // stb = {load_ir, inc_pc, load_pc, sel_pc, load_reg, halt}; flg = {z, n, c}
   typedef struct {
      logic [7:0] acc;
      logic [2:0] flg;
      logic [5:0] stb;
      int         id;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   ncyc   = 0;

   // Model: phase 0 = fetch, 1 = execute, 2 = halted
   int phase = 0;
   int macc  = 0;
   bit mz = 0, mn = 0, mc = 0;

   task automatic cyc(input bit r, input logic [7:0] ins, input logic [7:0] rd);
      exp_t e;
      int   op, imm, rdi, t;
      bit   alu;
      reset    = r;
      instr    = ins;
      reg_data = rd;
      op  = int'(ins[7:4]);
      imm = int'(ins[3:0]);
      rdi = int'(rd);
      e.acc = 8'(macc);
      e.flg = {mz, mn, mc};
      e.stb = 6'b000000;
      e.id  = ncyc;
      if (!r) begin
         if (phase == 0) e.stb = 6'b110000;
         else if (phase == 2) e.stb = 6'b000001;
         else begin
            if (op == 3) e.stb = 6'b000010;
            if (op == 12 || (op == 13 && mz) || (op == 14 && mn)) e.stb = 6'b001100;
         end
      end
      q.push_back(e);
      ncyc++;
      @(posedge clk);
      if (r) begin
         phase = 0; macc = 0; mz = 0; mn = 0; mc = 0;
      end else if (phase == 0) begin
         phase = 1;
      end else if (phase == 1) begin
         alu = 1;
         case (op)
            1: begin macc = imm; alu = 0; end
            2: begin macc = rdi; alu = 0; end
            4: begin t = macc + rdi; mc = (t > 255); macc = t % 256; end
            5: begin mc = (macc < rdi); macc = (macc - rdi + 256) % 256; end
            6: begin macc = macc & rdi; mc = 0; end
            7: begin macc = macc | rdi; mc = 0; end
            8: begin macc = macc ^ rdi; mc = 0; end
            9: begin macc = 255 - macc; mc = 0; end
            10: begin mc = (macc >= 128); macc = (macc * 2) % 256; end
            11: begin mc = (macc % 2) == 1; macc = macc / 2; end
            default: alu = 0;
         endcase
         if (alu) begin
            mz = (macc == 0);
            mn = (macc >= 128);
         end
         phase = (op == 15) ? 2 : 0;
      end
      #1;
   endtask

   task automatic run_instr(input logic [7:0] ins, input logic [7:0] rd);
      cyc(1'b0, ins, rd);
      cyc(1'b0, ins, rd);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if ({load_ir, inc_pc, load_pc, sel_pc, load_reg, halt} !== e.stb) begin
            errors++;
            $display("FAIL strobes cycle %0d: got %b expected %b", e.id,
                     {load_ir, inc_pc, load_pc, sel_pc, load_reg, halt}, e.stb);
         end
         checks++;
         if (acc_out !== e.acc) begin
            errors++;
            $display("FAIL acc cycle %0d: got %h expected %h", e.id, acc_out, e.acc);
         end
         checks++;
         if ({flag_z, flag_n, flag_c} !== e.flg) begin
            errors++;
            $display("FAIL flags(znc) cycle %0d: got %b expected %b", e.id,
                     {flag_z, flag_n, flag_c}, e.flg);
         end
      end
   end

   initial begin
      logic [7:0] ri;
      int         wait_cnt;
      reset    = 1'b1;
      instr    = 8'h00;
      reg_data = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      cyc(1'b1, 8'h00, 8'h00);
      // LDI 5; ADD 3
      run_instr(8'h15, 8'h00);
      run_instr(8'h41, 8'h03);
      // LDI 0; SUB 1 -> FF; ADD 1 -> 00 with carry
      run_instr(8'h10, 8'h00);
      run_instr(8'h51, 8'h01);
      run_instr(8'h41, 8'h01);
      // LDI F; STR
      run_instr(8'h1F, 8'h00);
      run_instr(8'h3A, 8'h55);
      // Z still set: JZ taken; then clear Z and JZ not taken; JMP
      run_instr(8'hD7, 8'h00);
      run_instr(8'h11, 8'h00);
      run_instr(8'h41, 8'h00);
      run_instr(8'hD7, 8'h00);
      run_instr(8'hC3, 8'h00);
      // shifts and JN both ways
      run_instr(8'h18, 8'h00);
      run_instr(8'hA0, 8'h00);
      run_instr(8'hA0, 8'h00);
      run_instr(8'hE4, 8'h00);
      run_instr(8'hB0, 8'h00);
      run_instr(8'hE4, 8'h00);
      run_instr(8'h9F, 8'h00);
      run_instr(8'hE4, 8'h00);
      // halt and stay halted
      run_instr(8'hF0, 8'h00);
      for (int i = 0; i < 12; i++) cyc(1'b0, 8'(i * 17), 8'h00);
      cyc(1'b1, 8'h00, 8'h00);
      // reset during EXECUTE of ADD
      cyc(1'b0, 8'h47, 8'h07);
      cyc(1'b1, 8'h47, 8'h07);
      run_instr(8'h15, 8'h00);
      // random stream
      for (int i = 0; i < 3000; i++) begin
         bit r;
         ri = 8'($urandom);
         if (ri[7:4] == 4'hF && $urandom_range(0, 3) != 0) ri[7:4] = 4'h4;
         r = ($urandom_range(0, 59) == 0) || (phase == 2 && $urandom_range(0, 9) == 0);
         cyc(r, ri, 8'($urandom));
      end
      wait_cnt = 0;
      while (q.size() > 0 && wait_cnt < 10) begin
         @(posedge clk);
         wait_cnt++;
      end
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
